// File: rtl/filter_accum_sat.sv
// Tap-product accumulator with rounding and saturation to 8-bit pixels.
// ACC gathers a sample's products; OUT holds the pixel until it is taken.
module filter_accum_sat #(
  parameter int NUM_TAPS = 9,
  parameter int SHIFT    = 20
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [28:0] prod_data,
  input  logic        prod_valid,
  input  logic        prod_last,
  output logic        prod_ready,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sat_sticky,
  output logic        err_sticky
);

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  localparam logic [3:0]  LAST_CNT = 4'(NUM_TAPS - 1);
  localparam logic [33:0] RND      = 34'(1) << (SHIFT - 1);

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  pix_q, pix_d;
  logic        sat_q, sat_d;
  logic        err_q, err_d;

  logic        take;
  logic        at_end;
  logic        fin;
  logic [32:0] sum;
  logic [33:0] rnd;

  assign take   = prod_valid && (state_q == ACC);
  assign at_end = (cnt_q == LAST_CNT);
  assign fin    = at_end || prod_last;
  // First beat of a sample loads instead of adding.
  assign sum    = (cnt_q == 4'd0) ? {4'b0, prod_data}
                                  : acc_q + {4'b0, prod_data};
  assign rnd    = ({1'b0, sum} + RND) >> SHIFT;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    sat_d   = sat_q;
    err_d   = err_q;
    unique case (state_q)
      ACC: begin
        if (take) begin
          acc_d = sum;
          if (fin) begin
            state_d = OUT;
            if (rnd > 34'd255) begin
              pix_d = 8'hFF;
              sat_d = 1'b1;
            end else begin
              pix_d = rnd[7:0];
            end
            if (prod_last != at_end) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (pix_ready) begin
          state_d = ACC;
          cnt_d   = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign prod_ready = (state_q == ACC);
  assign pix_valid  = (state_q == OUT);
  assign pix_data   = pix_q;
  assign sat_sticky = sat_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_filter_accum_sat.sv
// Scoreboard bench for filter_accum_sat at NUM_TAPS=9, SHIFT=20.
// Inputs change and outputs are sampled on the falling edge.
module tb_filter_accum_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [28:0] prod_data;
  logic        prod_valid;
  logic        prod_last;
  logic        prod_ready;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        sat_sticky;
  logic        err_sticky;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] expq[$];

  filter_accum_sat #(.NUM_TAPS(9), .SHIFT(20)) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .prod_data(prod_data),
    .prod_valid(prod_valid),
    .prod_last(prod_last),
    .prod_ready(prod_ready),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .sat_sticky(sat_sticky),
    .err_sticky(err_sticky)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  function automatic logic [7:0] model(input logic [32:0] s);
    logic [33:0] r;
    r = ({1'b0, s} + 34'd524288) >> 20;
    return (r > 34'd255) ? 8'd255 : r[7:0];
  endfunction

  task automatic send_beat(input logic [28:0] d, input logic l);
    int n;
    prod_data  = d;
    prod_valid = 1'b1;
    prod_last  = l;
    n = 0;
    while (!prod_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!prod_ready) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout prod_ready=%0b required 1", prod_ready);
    end
    @(negedge ap_clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic send_sample(input logic [28:0] first, input logic [28:0] rest,
                             input int nb, input int lastpos);
    logic [32:0] s;
    s = '0;
    for (int i = 1; i <= nb; i++) begin
      s = s + 33'(i == 1 ? first : rest);
      send_beat(i == 1 ? first : rest, i == lastpos);
    end
    expq.push_back(model(s));
  endtask

  task automatic wait_pix(output bit ok);
    int n;
    n = 0;
    while (!pix_valid && n < 30) begin
      @(negedge ap_clk);
      n++;
    end
    ok = pix_valid;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (pix_valid !== 1'b0 || prod_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_hs pix_valid=%0b prod_ready=%0b required 0/1",
               pix_valid, prod_ready);
    end
    tests++;
    if (pix_data !== 8'd0 || sat_sticky !== 1'b0 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs pix=%0d sat=%0b err=%0b required 0/0/0",
               pix_data, sat_sticky, err_sticky);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    send_sample(29'h0100000, 29'h0100000, 9, 9);
    tests++;
    if (pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency pix_valid=%0b required 1", pix_valid);
    end
    e = expq.pop_front();
    tests++;
    if (pix_data !== e || e !== 8'd9) begin
      fails++;
      $display("FAIL basic_pix got %0d required %0d", pix_data, e);
    end
    tests++;
    if (sat_sticky !== 1'b0 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags sat=%0b err=%0b required 0/0",
               sat_sticky, err_sticky);
    end
    @(negedge ap_clk);
    tests++;
    if (pix_valid !== 1'b0 || prod_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release pix_valid=%0b prod_ready=%0b required 0/1",
               pix_valid, prod_ready);
    end
  endtask

  task automatic test_rounding();
    logic [28:0] f[2];
    logic [7:0] e;
    bit ok;
    f[0] = 29'h0080000;
    f[1] = 29'h007FFFF;
    for (int k = 0; k < 2; k++) begin
      send_sample(f[k], 29'h0, 9, 9);
      wait_pix(ok);
      e = expq.pop_front();
      tests++;
      if (!ok || pix_data !== e) begin
        fails++;
        $display("FAIL round_%0d got %0d valid=%0b required %0d",
                 k, pix_data, pix_valid, e);
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] e;
    bit ok;
    send_sample(29'h0200000, 29'h0300000, 9, 9);
    wait_pix(ok);
    t0 = cyc;
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e) begin
      fails++;
      $display("FAIL b2b_a got %0d required %0d", pix_data, e);
    end
    send_sample(29'h0123456, 29'h0054321, 9, 9);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e) begin
      fails++;
      $display("FAIL b2b_b got %0d required %0d", pix_data, e);
    end
    tests++;
    if (cyc - t0 != 10) begin
      fails++;
      $display("FAIL b2b_period got %0d cycles required 10", cyc - t0);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_stall();
    logic [7:0] e;
    logic [7:0] held;
    bit ok;
    pix_ready = 1'b0;
    send_sample(29'h0100000, 29'h0200000, 9, 9);
    held = pix_data;
    e = expq.pop_front();
    tests++;
    if (pix_valid !== 1'b1 || held !== e) begin
      fails++;
      $display("FAIL stall_pix got %0d required %0d", held, e);
    end
    prod_data  = 29'h0100000;
    prod_valid = 1'b1;
    prod_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      tests++;
      if (pix_valid !== 1'b1 || pix_data !== held || prod_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold_%0d pix=%0d v=%0b rdy=%0b required %0d/1/0",
                 i, pix_data, pix_valid, prod_ready, held);
      end
    end
    pix_ready = 1'b1;
    @(negedge ap_clk);
    tests++;
    if (prod_ready !== 1'b1 || pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release rdy=%0b v=%0b required 1/0",
               prod_ready, pix_valid);
    end
    // The beat held during OUT is taken now as beat 1.
    @(negedge ap_clk);
    prod_valid = 1'b0;
    for (int i = 2; i <= 9; i++) send_beat(29'h0100000, i == 9);
    expq.push_back(model(33'h0900000));
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e) begin
      fails++;
      $display("FAIL stall_next got %0d required %0d", pix_data, e);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    bit ok;
    send_sample(29'h1FFFFFFF, 29'h1FFFFFFF, 9, 9);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e || e !== 8'd255) begin
      fails++;
      $display("FAIL sat_pix got %0d required %0d", pix_data, e);
    end
    tests++;
    if (sat_sticky !== 1'b1 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL sat_flag sat=%0b err=%0b required 1/0",
               sat_sticky, err_sticky);
    end
    @(negedge ap_clk);
    send_sample(29'h0100000, 29'h0100000, 9, 9);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e || sat_sticky !== 1'b1) begin
      fails++;
      $display("FAIL sat_sticky pix=%0d sat=%0b required %0d/1",
               pix_data, sat_sticky, e);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_early_last();
    logic [7:0] e;
    bit ok;
    send_sample(29'h0100000, 29'h0100000, 3, 3);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e || e !== 8'd3) begin
      fails++;
      $display("FAIL early_pix got %0d required %0d", pix_data, e);
    end
    tests++;
    if (err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL early_err err=%0b required 1", err_sticky);
    end
    @(negedge ap_clk);
    send_sample(29'h0100000, 29'h0100000, 9, 9);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e) begin
      fails++;
      $display("FAIL early_next got %0d required %0d", pix_data, e);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_missing_last();
    do_reset();
    send_sample(29'h0100000, 29'h0100000, 9, 0);
    tests++;
    if (pix_valid !== 1'b1 || pix_data !== expq.pop_front() ||
        err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL nolast v=%0b pix=%0d err=%0b required 1/9/1",
               pix_valid, pix_data, err_sticky);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    bit ok;
    bit seen;
    for (int i = 1; i <= 4; i++) send_beat(29'h0100000, 1'b0);
    do_reset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (pix_valid) seen = 1;
      @(negedge ap_clk);
    end
    tests++;
    if (seen || sat_sticky !== 1'b0 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_quiet seen=%0b sat=%0b err=%0b required 0/0/0",
               seen, sat_sticky, err_sticky);
    end
    send_sample(29'h0100000, 29'h0100000, 9, 9);
    wait_pix(ok);
    e = expq.pop_front();
    tests++;
    if (!ok || pix_data !== e || e !== 8'd9) begin
      fails++;
      $display("FAIL rstmid_next got %0d required %0d", pix_data, e);
    end
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst_n   = 1'b0;
    prod_data  = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    pix_ready  = 1'b1;
    @(negedge ap_clk);
    test_reset();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_stall();
    test_saturate();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
